// File: rtl/dmem_arbiter.sv
// Round-robin arbiter that shares one single-port data memory between two requesters.
// Each access is a two-cycle transaction: a latch cycle in IDLE, then one ACCESS cycle.
module dmem_arbiter #(
    parameter int DW    = 16,
    parameter int AW    = 16,
    parameter int DEPTH = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          a_ack,
    output logic          b_ack,
    output logic          a_err,
    output logic          b_err,
    output logic [DW-1:0] a_rdata,
    output logic [DW-1:0] b_rdata,
    output logic          mem_write,
    output logic          mem_read,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic {IDLE, ACCESS} state_t;

    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

    state_t        state_q, state_d;
    logic          ptr_q, ptr_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          a_ack_q, a_ack_d, b_ack_q, b_ack_d;
    logic          a_err_q, a_err_d, b_err_q, b_err_d;
    logic [DW-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

    logic          in_range;
    logic          winner;

    assign in_range = (addr_q < AW'(DEPTH));
    // A lone requester wins outright; on contention the pointer decides.
    assign winner   = (a_req && b_req) ? ptr_q : b_req;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        a_ack_d   = 1'b0;
        b_ack_d   = 1'b0;
        a_err_d   = 1'b0;
        b_err_d   = 1'b0;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        case (state_q)
            IDLE: begin
                if (a_req || b_req) begin
                    owner_d = winner;
                    ptr_d   = ~winner;
                    we_d    = (winner == OWN_B) ? b_we    : a_we;
                    addr_d  = (winner == OWN_B) ? b_addr  : a_addr;
                    wdata_d = (winner == OWN_B) ? b_wdata : a_wdata;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                // Strobes are gated by rst so a reset cycle can never commit a write.
                mem_write = we_q & in_range & rst;
                mem_read  = ~we_q & in_range & rst;
                state_d   = IDLE;
                if (owner_q == OWN_A) begin
                    a_ack_d = 1'b1;
                    a_err_d = ~in_range;
                    if (!we_q) a_rdata_d = in_range ? mem_rdata : '0;
                end else begin
                    b_ack_d = 1'b1;
                    b_err_d = ~in_range;
                    if (!we_q) b_rdata_d = in_range ? mem_rdata : '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            state_q   <= IDLE;
            ptr_q     <= OWN_A;
            owner_q   <= OWN_A;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_err_q   <= 1'b0;
            b_err_q   <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            a_ack_q   <= a_ack_d;
            b_ack_q   <= b_ack_d;
            a_err_q   <= a_err_d;
            b_err_q   <= b_err_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    assign a_ack   = a_ack_q;
    assign b_ack   = b_ack_q;
    assign a_err   = a_err_q;
    assign b_err   = b_err_q;
    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port round-robin arbiter that shares the single-port data memory between requester A (core load/store path) and requester B (debug/DMA loader). It sequences every access as a two-cycle transaction, drives the memory's read/write strobes, address and write data, and captures read data. It also rejects addresses outside the memory depth. It sits directly in front of the data memory, replacing direct core wiring to the memory ports.

## Interface
- DW, 16, data width
- AW, 16, address width
- DEPTH, 24, number of memory words; valid addresses 0..DEPTH-1
- clk  in  1  single clock, all state updates on posedge
- rst  in  1  reset, synchronous, active-low (shared with data memory)
- a_req, b_req  in  1  request; held with command stable until matching ack
- a_we, b_we  in  1  1 = write, 0 = read
- a_addr, b_addr  in  AW  word address
- a_wdata, b_wdata  in  DW  write data
- a_ack, b_ack  out  1  one-cycle completion pulse, registered
- a_err, b_err  out  1  out-of-range flag, valid with ack only
- a_rdata, b_rdata  out  DW  read data, registered; holds value until that port's next ack
- mem_write, mem_read  out  1  strobes to memory
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data (combinational from mem_addr when mem_read=1)

## Operation
- FSM states: IDLE, ACCESS.
- IDLE: if any req is high at the posedge, latch the winner's we/addr/wdata and owner id, and go to ACCESS. Otherwise stay in IDLE.
- Arbitration: a single requester wins unconditionally. If both request, the side named by the priority pointer wins. After every grant, the pointer moves to the non-winning side.
- ACCESS lasts exactly one cycle and is driven only from the latched command:
  - mem_addr = latched addr.
  - mem_wdata = latched wdata.
  - mem_write = we & in_range.
  - mem_read = ~we & in_range.
  - in_range = latched addr < DEPTH.
- At the ACCESS-closing posedge:
  - Owner's ack is set for the next cycle.
  - err = ~in_range.
  - For a read, owner's rdata ← mem_rdata if in_range, else 0.
  - For a write, rdata is unchanged.
  - State returns to IDLE.
- Outside ACCESS: mem_write = mem_read = 0, mem_addr = 0, mem_wdata = 0.
- Out-of-range access: no strobe is issued, memory contents are unchanged, and ack+err are returned.
- Requester protocol: req sampled high in the ack cycle (IDLE) is treated as a new request. A requester wanting one access must drop req in its ack cycle.
- Only one ack is high in any cycle; ack and err are never set for the non-owner.

## Timing
- Reset (rst=0 at posedge): state IDLE, pointer = A, all ack/err 0, a_rdata = b_rdata = 0, latched command cleared.
- mem_write and mem_read are additionally gated by rst, so no write is issued in a reset cycle.
- Reset during ACCESS aborts the transaction: no ack is issued, and the requester must re-request.
- Latency:
  - Cycle 0 (IDLE): req high.
  - Cycle 1: ACCESS, with strobes high.
  - Cycle 2: ack high, rdata valid.
- Throughput: one access per 2 cycles. Back-to-back contention alternates A, B, A, B.
- Memory write commits at the ACCESS-closing edge.
- Read data is sampled at the same edge from the combinational mem_rdata.

## Test plan
- Reset then idle: all outputs 0, no mem strobes for 10 cycles; rst low mid-ACCESS → no ack, state IDLE.
- A writes 0xBEEF to addr 5, then reads addr 5 → a_ack at cycle 2 of each transaction, a_rdata = 0xBEEF, a_err = 0; b_ack stays 0.
- Directed tests that rely on the memory's reset-loaded contents:
  - After reset, B reads addr 8 → b_rdata = 0xE128, and a_rdata is unchanged.
  - A reads addr 23 → 0xFDB9.
- a_req and b_req both held high for 8 transactions after reset → grant order A, B, A, B, A, B, A, B, exactly one ack per two cycles.
- A writes to addr 24 and B reads addr 0xFFFF:
  - Each gets ack with err = 1, and b_rdata = 0.
  - mem_write and mem_read are never high.
  - A subsequent read of addr 23 still returns 0xFDB9.
- A holds req through its ack cycle → a second A access starts immediately when B is idle; if B requests in that same cycle, B wins per pointer.
